alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
- Moore FSM that sequences the alarm once the time/set comparator reports a match.
- Arms and disarms the alarm, starts ringing on a new match, and auto-stops ringing after a timeout.
- Handles snooze with a bounded repeat count and gates the buzzer with a 1 Hz blink.
- Sits between the comparator's match output, the debounced user buttons, and the buzzer/LED drivers.

Parameters:
- RING_TIMEOUT_S, 60, number of tick_1hz pulses spent in RINGING before auto-dismiss (legal range 1..255).
- SNOOZE_S, 300, number of tick_1hz pulses spent in SNOOZE before re-ringing (legal range 1..1023).
- MAX_SNOOZES, 3, snoozes allowed per alarm event (legal range 0..3).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- alarm_enable  in  1  level; arm switch; 0 forces DISARMED
- match  in  1  level; comparator output, high while current time equals set time in time mode
- tick_1hz  in  1  one-clk pulse, once per second
- snooze_btn  in  1  one-clk debounced pulse
- stop_btn  in  1  one-clk debounced pulse
- alarm_on  out  1  high in RINGING
- buzzer  out  1  alarm_on AND blink
- snoozing  out  1  high in SNOOZE
- snooze_cnt  out  2  snoozes used in the current alarm event
- state_dbg  out  3  state encoding

Behaviour:
- States and encodings: DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3, WAIT_CLEAR=4.
- Reset (async, rst_n=0):
  - state=DISARMED; match_q=0; blink=1; ring_cnt=0; snz_tmr=0; snooze_cnt=0.
  - All outputs are 0 and state_dbg=0.
- Output timing: all outputs decode from registers only. Any transition decided at edge N is visible after edge N.
- match_q registers match every clk in every state. Trigger condition is match & ~match_q (rising edge).
- Priority within a cycle, highest first: alarm_enable=0 > stop_btn > snooze_btn > timer expiry > trigger.
- Transitions:
  - Any state with alarm_enable=0 → DISARMED. snooze_cnt clears.
  - DISARMED with alarm_enable=1 → ARMED. If match is already high when enabling, no ring occurs (no rising edge).
  - ARMED with trigger → RINGING. ring_cnt=0, blink=1, snooze_cnt=0.
  - RINGING with stop_btn → WAIT_CLEAR.
  - RINGING with snooze_btn and snooze_cnt<MAX_SNOOZES → SNOOZE. snz_tmr=SNOOZE_S, snooze_cnt+1.
  - RINGING with snooze_btn and snooze_cnt==MAX_SNOOZES → button ignored; remain in RINGING.
  - RINGING with tick_1hz → ring_cnt+1 and blink toggles. If ring_cnt==RING_TIMEOUT_S-1 → WAIT_CLEAR.
  - SNOOZE with stop_btn → WAIT_CLEAR.
  - SNOOZE with tick_1hz → snz_tmr-1. If snz_tmr==1 → RINGING with ring_cnt=0, blink=1.
  - SNOOZE with snooze_btn → ignored.
  - WAIT_CLEAR with match=0 → ARMED. This prevents re-triggering within the same matching minute.
- Exiting WAIT_CLEAR to ARMED needs match=0; a new rising edge is still required to ring again.
- snooze_cnt holds its value through WAIT_CLEAR and ARMED. It clears on the next trigger or on DISARMED.
- Buttons and tick in the same cycle follow the priority above. Example: stop and tick together in RINGING → WAIT_CLEAR, and ring_cnt is don't-care.
- ring_cnt is 8 bits and snz_tmr is 10 bits. Neither wraps: both are reloaded on state entry.
- Mid-ring reset: outputs go to 0 asynchronously. After release the FSM starts in DISARMED.

Test Plan:
- Use RING_TIMEOUT_S=5, SNOOZE_S=3, MAX_SNOOZES=2 for all scenarios.
1. Reset then enable=1 → state_dbg=1. Raise match → next clk alarm_on=1, buzzer=1. Then 5 ticks → buzzer toggles 1,0,1,0,1 and state becomes WAIT_CLEAR (4) after the 5th tick. Drop match → state=1.
2. Ringing, pulse snooze_btn → snoozing=1, snooze_cnt=1, alarm_on=0. After 3 ticks → alarm_on=1 again. Snooze again → snooze_cnt=2. After 3 ticks it rings again; a third snooze_btn is ignored (state stays 2).
3. Ringing, stop_btn and snooze_btn in the same clk → state=4, snooze_cnt unchanged. Holding match high keeps state 4 for 100 clks.
4. Match high before enable rises → state goes 0→1 and alarm_on stays 0. Pulse match low then high → rings.
5. In SNOOZE, drop alarm_enable → next clk state=0, snooze_cnt=0, snoozing=0.
6. Assert rst_n=0 mid-RINGING between clock edges → alarm_on and buzzer go to 0 immediately. After release, state=0.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm sequencing FSM: arm, ring on match edge, snooze, timeout.
// Buzzer is gated by a 1 Hz blink that restarts high on every ring entry.
module alarm_sequencer #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm_enable,
    input  logic       match,
    input  logic       tick_1hz,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       alarm_on,
    output logic       buzzer,
    output logic       snoozing,
    output logic [1:0] snooze_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        DISARMED   = 3'd0,
        ARMED      = 3'd1,
        RINGING    = 3'd2,
        SNOOZE     = 3'd3,
        WAIT_CLEAR = 3'd4
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);
    localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_S);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZES);

    state_t     state;
    logic       match_q;
    logic       blink;
    logic [7:0] ring_cnt;
    logic [9:0] snz_tmr;
    logic       trigger;

    assign trigger = match & ~match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DISARMED;
            match_q    <= 1'b0;
            blink      <= 1'b1;
            ring_cnt   <= 8'd0;
            snz_tmr    <= 10'd0;
            snooze_cnt <= 2'd0;
        end else begin
            match_q <= match;
            if (!alarm_enable) begin
                state      <= DISARMED;
                snooze_cnt <= 2'd0;
            end else begin
                unique case (state)
                    DISARMED: state <= ARMED;
                    ARMED: begin
                        if (trigger) begin
                            state      <= RINGING;
                            ring_cnt   <= 8'd0;
                            blink      <= 1'b1;
                            snooze_cnt <= 2'd0;
                        end
                    end
                    RINGING: begin
                        if (stop_btn) begin
                            state <= WAIT_CLEAR;
                        end else if (snooze_btn && snooze_cnt < SNZ_MAX) begin
                            state      <= SNOOZE;
                            snz_tmr    <= SNZ_LOAD;
                            snooze_cnt <= snooze_cnt + 2'd1;
                        end else if (tick_1hz) begin
                            ring_cnt <= ring_cnt + 8'd1;
                            blink    <= ~blink;
                            if (ring_cnt == RING_LAST)
                                state <= WAIT_CLEAR;
                        end
                    end
                    SNOOZE: begin
                        if (stop_btn) begin
                            state <= WAIT_CLEAR;
                        end else if (tick_1hz) begin
                            snz_tmr <= snz_tmr - 10'd1;
                            if (snz_tmr == 10'd1) begin
                                state    <= RINGING;
                                ring_cnt <= 8'd0;
                                blink    <= 1'b1;
                            end
                        end
                    end
                    WAIT_CLEAR: begin
                        // Hold off until the matching minute has passed
                        if (!match)
                            state <= ARMED;
                    end
                    default: state <= DISARMED;
                endcase
            end
        end
    end

    assign alarm_on  = (state == RINGING);
    assign buzzer    = alarm_on & blink;
    assign snoozing  = (state == SNOOZE);
    assign state_dbg = state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: directed steps push expected
// outputs, a monitor pops and compares on the falling clock edge.
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alarm_enable, match, tick_1hz, snooze_btn, stop_btn;
    logic       alarm_on, buzzer, snoozing;
    logic [1:0] snooze_cnt;
    logic [2:0] state_dbg;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       ao;
        logic       bz;
        logic       sn;
        logic [1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    event chk_now;

    alarm_sequencer #(
        .RING_TIMEOUT_S(5),
        .SNOOZE_S(3),
        .MAX_SNOOZES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alarm_enable(alarm_enable),
        .match(match),
        .tick_1hz(tick_1hz),
        .snooze_btn(snooze_btn),
        .stop_btn(stop_btn),
        .alarm_on(alarm_on),
        .buzzer(buzzer),
        .snoozing(snoozing),
        .snooze_cnt(snooze_cnt),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic expect_o(input string nm, input logic [2:0] st,
                            input logic ao, input logic bz,
                            input logic sn, input logic [1:0] cnt);
        exp_t e;
        e.name = nm;
        e.st   = st;
        e.ao   = ao;
        e.bz   = bz;
        e.sn   = sn;
        e.cnt  = cnt;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tick_1hz   = 1'b0;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step();
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_now);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_chk++;
                if ({state_dbg, alarm_on, buzzer, snoozing, snooze_cnt} !==
                    {e.st, e.ao, e.bz, e.sn, e.cnt}) begin
                    n_fail++;
                    $display("FAIL %s: got st=%0d on=%b bz=%b snz=%b cnt=%0d, want st=%0d on=%b bz=%b snz=%b cnt=%0d",
                             e.name, state_dbg, alarm_on, buzzer, snoozing,
                             snooze_cnt, e.st, e.ao, e.bz, e.sn, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        alarm_enable = 1'b0;
        match        = 1'b0;
        tick_1hz     = 1'b0;
        snooze_btn   = 1'b0;
        stop_btn     = 1'b0;
        repeat (2) step();
        expect_o("reset", 3'd0, 0, 0, 0, 2'd0);

        // 1: ring, blink, timeout, clear
        step();
        rst_n        = 1'b1;
        alarm_enable = 1'b1;
        step();
        expect_o("arm", 3'd1, 0, 0, 0, 2'd0);
        match = 1'b1;
        step();
        expect_o("ring", 3'd2, 1, 1, 0, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            expect_o($sformatf("blink%0d", i), 3'd2, 1, (i % 2 == 0), 0, 2'd0);
        end
        tick();
        expect_o("timeout", 3'd4, 0, 0, 0, 2'd0);
        match = 1'b0;
        step();
        expect_o("clear", 3'd1, 0, 0, 0, 2'd0);

        // 3: stop beats snooze; WAIT_CLEAR held while match high
        match = 1'b1;
        step();
        expect_o("ring3", 3'd2, 1, 1, 0, 2'd0);
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        step();
        expect_o("stop_prio", 3'd4, 0, 0, 0, 2'd0);
        for (int i = 0; i < 100; i++) begin
            step();
            expect_o("hold_wc", 3'd4, 0, 0, 0, 2'd0);
        end
        match = 1'b0;
        step();
        expect_o("clear3", 3'd1, 0, 0, 0, 2'd0);

        // 2: snooze twice, third ignored
        match = 1'b1;
        step();
        expect_o("ring2", 3'd2, 1, 1, 0, 2'd0);
        snooze_btn = 1'b1;
        step();
        expect_o("snz1", 3'd3, 0, 0, 1, 2'd1);
        tick();
        expect_o("snz1_t1", 3'd3, 0, 0, 1, 2'd1);
        tick();
        expect_o("snz1_t2", 3'd3, 0, 0, 1, 2'd1);
        tick();
        expect_o("rering1", 3'd2, 1, 1, 0, 2'd1);
        snooze_btn = 1'b1;
        step();
        expect_o("snz2", 3'd3, 0, 0, 1, 2'd2);
        repeat (2) begin
            tick();
            expect_o("snz2_t", 3'd3, 0, 0, 1, 2'd2);
        end
        tick();
        expect_o("rering2", 3'd2, 1, 1, 0, 2'd2);
        snooze_btn = 1'b1;
        step();
        expect_o("snz_max", 3'd2, 1, 1, 0, 2'd2);
        snooze_btn = 1'b1;
        tick();
        expect_o("snz_max_tick", 3'd2, 1, 0, 0, 2'd2);
        stop_btn = 1'b1;
        step();
        expect_o("stop2", 3'd4, 0, 0, 0, 2'd2);
        match = 1'b0;
        step();
        expect_o("cnt_hold", 3'd1, 0, 0, 0, 2'd2);
        match = 1'b1;
        step();
        expect_o("cnt_clr", 3'd2, 1, 1, 0, 2'd0);
        stop_btn = 1'b1;
        step();
        expect_o("stop2b", 3'd4, 0, 0, 0, 2'd0);

        // 4: match already high when enabling
        alarm_enable = 1'b0;
        step();
        expect_o("dis4", 3'd0, 0, 0, 0, 2'd0);
        alarm_enable = 1'b1;
        step();
        expect_o("arm4", 3'd1, 0, 0, 0, 2'd0);
        step();
        expect_o("no_edge", 3'd1, 0, 0, 0, 2'd0);
        match = 1'b0;
        step();
        expect_o("low4", 3'd1, 0, 0, 0, 2'd0);
        match = 1'b1;
        step();
        expect_o("ring4", 3'd2, 1, 1, 0, 2'd0);

        // 5: disable while snoozing
        snooze_btn = 1'b1;
        step();
        expect_o("snz5", 3'd3, 0, 0, 1, 2'd1);
        snooze_btn = 1'b1;
        step();
        expect_o("snz_in_snz", 3'd3, 0, 0, 1, 2'd1);
        alarm_enable = 1'b0;
        step();
        expect_o("dis5", 3'd0, 0, 0, 0, 2'd0);

        // 6: async reset mid-ring
        alarm_enable = 1'b1;
        match        = 1'b0;
        step();
        expect_o("arm6", 3'd1, 0, 0, 0, 2'd0);
        match = 1'b1;
        step();
        expect_o("ring6", 3'd2, 1, 1, 0, 2'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        expect_o("async_rst", 3'd0, 0, 0, 0, 2'd0);
        -> chk_now;
        step();
        rst_n = 1'b1;
        expect_o("released", 3'd0, 0, 0, 0, 2'd0);
        step();
        expect_o("rearm6", 3'd1, 0, 0, 0, 2'd0);

        for (int i = 0; i < 5 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
